// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux_scan channel selector.
package mux_scan_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_sel.sv
// Combinational N:1 selector of W-bit slices from a flattened bus.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic [N*W-1:0]         din,
  input  logic [$clog2(N)-1:0]   idx,
  output logic [W-1:0]           dout
);

  localparam int SW = $clog2(N);

  always_comb begin
    dout = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SW'(k)) dout = din[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel mux with manual select and auto-scan modes.
// Optional freeze input enabled by defining MUX_SCAN_HOLD_EN.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MUX_SCAN_HOLD_EN
  input  logic                 hold,
`endif
  input  logic                 mode,
  input  logic [$clog2(N)-1:0] sel,
  input  logic [N*W-1:0]       din,
  output logic [W-1:0]         f,
  output logic [$clog2(N)-1:0] ch,
  output logic                 ch_vld
);

  localparam int SW = $clog2(N);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW:0]   N_EXT    = (SW+1)'(N);
  localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  f_q, f_d;
  logic          vld_q;
  logic          hold_w;

`ifdef MUX_SCAN_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // The rule of the state being entered governs the current edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MANUAL:  if (mode == MODE_SCAN)   state_d = SCAN;
      SCAN:    if (mode == MODE_MANUAL) state_d = MANUAL;
      default: state_d = MANUAL;
    endcase

    ch_d  = ch_q;
    cnt_d = '0;
    if (state_d == SCAN) begin
      if (cnt_q == CNT_LAST) begin
        ch_d = (ch_q == CH_LAST) ? '0 : ch_q + SW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if ({1'b0, sel} < N_EXT) begin
      ch_d = sel;
    end
  end

  mux_scan_sel #(.N(N), .W(W)) u_sel (
    .din  (din),
    .idx  (ch_d),
    .dout (f_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
      ch_q    <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      vld_q   <= 1'b0;
    end else if (hold_w) begin
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      vld_q   <= (ch_d != ch_q);
    end
  end

  assign f      = f_q;
  assign ch     = ch_q;
  assign ch_vld = vld_q;

endmodule
